alu_multicycle: RTL and testbench
=================================

# alu_multicycle

Parametrised, registered successor to the combinational 8-bit datapath ALU. It accepts one operation per start pulse under a start/busy/done handshake and latches operands. Single-cycle logic and add ops run alongside iterative shifts (one bit per cycle) and an optional shift-add multiplier. It sits between the register file and the accumulator write-back, driven by the decoded control word.

## Interface
- WIDTH, 8, datapath width in bits (≥4).
- SHW, $clog2(WIDTH)+1, width of the internal shift/iteration counter.

- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; accepted only when busy=0.
- ctl  in  10  control word:
  - [0] za: zero A.
  - [1] ia: invert A.
  - [2] zb: zero B.
  - [3] ib: invert B.
  - [4] io: invert output.
  - [5] ce: carry-in enable.
  - [8:6] mode: 0 add, 1 and, 2 shr, 3 shl, 4 mul, 5 or, 6 xor, 7 add.
  - [9] cmp.
- a, b  in  WIDTH  operands, sampled at accept.
- cin  in  1  carry-in, sampled at accept.
- busy  out  1  operation in flight.
- done  out  1  one-cycle pulse, result valid.
- result  out  WIDTH  held from done until the next done.
- carryout, overout, zero, neg  out  1 each  flags, held with result.
- cmpo  out  1  latched ctl[9], updated with done.

## Operation
- At accept: xa = (za?0:a)^{WIDTH{ia}}, xb = (zb?0:b)^{WIDTH{ib}}, c = ce&cin. All three are registered, as are mode/io/cmp.
- States: IDLE → (accept) EXEC → DONE → IDLE.
  - EXEC loops for iterative modes.
  - DONE asserts done for one cycle, with busy=1 in EXEC only.
- add: sum = xa+xb+c (WIDTH+1 bits); carryout=sum[WIDTH]. overout = (~r[MSB]&xa[MSB]&xb[MSB]) | (r[MSB]&~xa[MSB]&~xb[MSB]), with r after io.
- and/or/xor: bitwise; carryout=0, overout=0.
- shr/shl: count s = min(xb, WIDTH), logical shift of xa one bit per EXEC cycle. carryout = last bit shifted out (0 if s=0); overout=0.
- mul: unsigned shift-add over WIDTH iterations; result = low WIDTH bits. carryout = OR of high WIDTH bits; overout=0.
- io inverts the final result before flags zero (result==0) and neg (result[MSB]) are computed. carryout/overout are not inverted.
- start while busy=1 or during DONE: ignored, no queueing.
- mode 7 behaves exactly as mode 0.

## Timing
- Reset values: busy=0, done=0, result=0, all flags=0, cmpo=0, state IDLE, counter 0.
- Reset mid-operation aborts immediately. No done is produced for the aborted op.
- Latency, measured from the accept edge to the done-high cycle:
  - add/and/or/xor: 2 cycles (1 EXEC + DONE).
  - shr/shl: 2+s cycles.
  - mul: 2+WIDTH cycles.
- Throughput: the next start is accepted in the cycle done is high, or any later IDLE cycle. Back-to-back gap is therefore 0 idle cycles after done.
- result and flags change only on the edge that raises done.
- Inputs a/b/ctl/cin may change freely after the accept edge.

## Configuration
- ALU_MUL_EN defined: mode 4 is the iterative multiplier as above.
- ALU_MUL_EN undefined:
  - Multiplier hardware is removed.
  - mode 4 decodes as add: 2-cycle latency, add flags.

## Test plan
- WIDTH=8, ctl add, a=0x7F, b=0x01, cin=0 → done 2 cycles after accept; result=0x80, overout=1, carryout=0, neg=1, zero=0.
- Subtract (ib=1, ce=1, cin=1), a=0x05, b=0x05 → result=0x00, zero=1, carryout=1, overout=0.
- shl, a=0x81, b=0x03 → busy for 4 EXEC cycles, done at cycle 5; result=0x08, carryout=0. Then shr with b=0x09 → s=8, result=0x00, done at cycle 10.
- mul (ALU_MUL_EN), a=0x10, b=0x11 → done at cycle 10; result=0x10, carryout=1. Without ALU_MUL_EN, same stimulus → result=0x21, done at cycle 2.
- start held high during a shl op, with differing a/b → ignored; first result intact. Second op accepted on the done cycle, and its done follows with correct latency.
- rst_n low for 1 cycle mid-mul → all outputs 0 asynchronously. No done pulse; the next add completes normally.

Source files
------------

// File: rtl/alu_multicycle.sv
// Registered multi-cycle ALU: start/busy/done handshake, iterative shifts, and an
// optional shift-add multiplier enabled by defining ALU_MUL_EN (otherwise mode 4 is add).
module alu_multicycle #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [9:0]       ctl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carryout,
    output logic             overout,
    output logic             zero,
    output logic             neg,
    output logic             cmpo,
    output logic [1:0]       state_o
);

    // Handshake: start is taken on a rising edge where busy=0 (IDLE or the done
    // cycle); done pulses for one cycle and result/flags hold until the next done.
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

    localparam int MSB = WIDTH - 1;

    state_t           state_q;
    logic [WIDTH-1:0] xa_q, xb_q;
    logic             c_q, io_q, cmp_q, shc_q;
    logic [2:0]       mode_q;
    logic [SHW-1:0]   cnt_q;
    logic             busy_q, done_q, carry_q, over_q, zero_q, neg_q, cmpo_q;
    logic [WIDTH-1:0] result_q;
`ifdef ALU_MUL_EN
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH:0]   mul_sum;
`endif

    logic [WIDTH-1:0] xa_d, xb_d, raw_d, res_d;
    logic [SHW-1:0]   cnt_d;
    logic [WIDTH:0]   sum;
    logic             co_d, ov_d, add_op;

    // Operand conditioning at accept time.
    always_comb begin
        xa_d = (ctl[0] ? '0 : a) ^ {WIDTH{ctl[1]}};
        xb_d = (ctl[2] ? '0 : b) ^ {WIDTH{ctl[3]}};
        cnt_d = '0;
        if (ctl[8:6] == 3'd2 || ctl[8:6] == 3'd3)
            cnt_d = (xb_d >= WIDTH'(WIDTH)) ? SHW'(WIDTH) : xb_d[SHW-1:0];
`ifdef ALU_MUL_EN
        else if (ctl[8:6] == 3'd4)
            cnt_d = SHW'(WIDTH);
`endif
    end

    assign sum = {1'b0, xa_q} + {1'b0, xb_q} + {{WIDTH{1'b0}}, c_q};
`ifdef ALU_MUL_EN
    // {hi_q, xb_q} is the running product; the multiplier bits drain out of xb_q.
    assign mul_sum = {1'b0, hi_q} + (xb_q[0] ? {1'b0, xa_q} : '0);
`endif

    // Final result and flags, evaluated in the last EXEC cycle.
    always_comb begin
        raw_d  = sum[WIDTH-1:0];
        co_d   = sum[WIDTH];
        add_op = 1'b1;
        case (mode_q)
            3'd1: begin raw_d = xa_q & xb_q; co_d = 1'b0; add_op = 1'b0; end
            3'd5: begin raw_d = xa_q | xb_q; co_d = 1'b0; add_op = 1'b0; end
            3'd6: begin raw_d = xa_q ^ xb_q; co_d = 1'b0; add_op = 1'b0; end
            3'd2, 3'd3: begin raw_d = xa_q; co_d = shc_q; add_op = 1'b0; end
`ifdef ALU_MUL_EN
            3'd4: begin raw_d = xb_q; co_d = |hi_q; add_op = 1'b0; end
`endif
            default: ;
        endcase
        res_d = raw_d ^ {WIDTH{io_q}};
        ov_d  = add_op & ((~res_d[MSB] & xa_q[MSB] & xb_q[MSB]) |
                          (res_d[MSB] & ~xa_q[MSB] & ~xb_q[MSB]));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            xa_q     <= '0;
            xb_q     <= '0;
            c_q      <= 1'b0;
            io_q     <= 1'b0;
            cmp_q    <= 1'b0;
            shc_q    <= 1'b0;
            mode_q   <= 3'd0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
            over_q   <= 1'b0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            cmpo_q   <= 1'b0;
`ifdef ALU_MUL_EN
            hi_q     <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_EXEC: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                        if (mode_q == 3'd3) begin
                            shc_q <= xa_q[MSB];
                            xa_q  <= xa_q << 1;
                        end else if (mode_q == 3'd2) begin
                            shc_q <= xa_q[0];
                            xa_q  <= xa_q >> 1;
                        end
`ifdef ALU_MUL_EN
                        else begin
                            hi_q <= mul_sum[WIDTH:1];
                            xb_q <= {mul_sum[0], xb_q[WIDTH-1:1]};
                        end
`endif
                    end else begin
                        state_q  <= S_DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        result_q <= res_d;
                        carry_q  <= co_d;
                        over_q   <= ov_d;
                        zero_q   <= (res_d == '0);
                        neg_q    <= res_d[MSB];
                        cmpo_q   <= cmp_q;
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new operation.
                    if (start && !busy_q) begin
                        state_q <= S_EXEC;
                        busy_q  <= 1'b1;
                        xa_q    <= xa_d;
                        xb_q    <= xb_d;
                        c_q     <= ctl[5] & cin;
                        io_q    <= ctl[4];
                        cmp_q   <= ctl[9];
                        mode_q  <= ctl[8:6];
                        cnt_q   <= cnt_d;
                        shc_q   <= 1'b0;
`ifdef ALU_MUL_EN
                        hi_q    <= '0;
`endif
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign carryout = carry_q;
    assign overout  = over_q;
    assign zero     = zero_q;
    assign neg      = neg_q;
    assign cmpo     = cmpo_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle (WIDTH=8): directed cases, randomized ops
// against an arithmetic reference model, hold/back-to-back start, and mid-op reset.
module tb_alu_multicycle;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [9:0] ctl;
  logic [7:0] a, b;
  logic       cin;
  logic       busy, done, carryout, overout, zero, neg, cmpo;
  logic [7:0] result;
  logic [1:0] state_o;

  int n_tests = 0;
  int n_fail  = 0;

  // expected {result, carryout, overout, zero, neg, cmpo}
  logic [12:0] exp_q[$];
  int          lat_q[$];
  logic [12:0] last_e;

  alu_multicycle #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ctl(ctl), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .result(result), .carryout(carryout),
    .overout(overout), .zero(zero), .neg(neg), .cmpo(cmpo), .state_o(state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
    end
  endtask

  function automatic logic [9:0] mk(input int mode, input bit za, input bit ia, input bit zb,
                                    input bit ib, input bit io, input bit ce, input bit cmp);
    logic [2:0] m;
    m = mode[2:0];
    return {cmp, m, ce, io, ib, zb, ia, za};
  endfunction

  // Reference model: plain integer arithmetic on the operation definition.
  function automatic void model(input logic [9:0] c_w, input logic [7:0] av, input logic [7:0] bv,
                                input logic ci, output logic [12:0] e, output int lat);
    int xa, xb, c, mode, s, r, co, ov, p;
    xa = c_w[0] ? 0 : int'(av);
    if (c_w[1]) xa = xa ^ 255;
    xb = c_w[2] ? 0 : int'(bv);
    if (c_w[3]) xb = xb ^ 255;
    c = (c_w[5] && ci) ? 1 : 0;
    mode = int'(c_w[8:6]);
    if (mode == 7) mode = 0;
`ifndef ALU_MUL_EN
    if (mode == 4) mode = 0;
`endif
    s = (xb > 8) ? 8 : xb;
    lat = 2; co = 0; ov = 0;
    case (mode)
      1: r = xa & xb;
      5: r = xa | xb;
      6: r = xa ^ xb;
      2: begin r = xa >> s; co = (s > 0) ? ((xa >> (s - 1)) & 1) : 0; lat = 2 + s; end
      3: begin r = (xa << s) & 255; co = (s > 0) ? ((xa >> (8 - s)) & 1) : 0; lat = 2 + s; end
      4: begin p = xa * xb; r = p & 255; co = (p > 255) ? 1 : 0; lat = 10; end
      default: begin r = xa + xb + c; co = r >> 8; r = r & 255; end
    endcase
    if (c_w[4]) r = r ^ 255;
    // signed overflow: operands share a sign that the (inverted-if-io) result lacks
    if (mode == 0 && ((xa >> 7) == (xb >> 7)) && ((r >> 7) != (xa >> 7))) ov = 1;
    e = {r[7:0], co[0], ov[0], (r == 0), r[7], c_w[9]};
  endfunction

  // driver: present an op, let it be accepted on the next edge, then scramble inputs
  task automatic issue(input logic [9:0] c_w, input logic [7:0] av, input logic [7:0] bv,
                       input logic ci);
    logic [12:0] e;
    int l;
    model(c_w, av, bv, ci, e, l);
    exp_q.push_back(e);
    lat_q.push_back(l);
    ctl = c_w; a = av; b = bv; cin = ci; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ctl = 10'($urandom); a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
  endtask

  // scoreboard: called just after the accept edge, waits for done and compares
  task automatic wait_done(input string tag, input int max_cyc);
    logic [12:0] e;
    int l, n;
    bit busy_ok;
    e = exp_q.pop_front();
    l = lat_q.pop_front();
    n = 0;
    busy_ok = 1'b1;
    while (done !== 1'b1 && n < max_cyc) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    if (done !== 1'b1) begin
      check({tag, "_timeout"}, 32'(n), 32'(l - 1));
    end else begin
      check({tag, "_latency"}, 32'(n + 1), 32'(l));
      check({tag, "_out"}, {19'b0, result, carryout, overout, zero, neg, cmpo}, {19'b0, e});
      check({tag, "_busy"}, {30'b0, busy_ok, busy}, 32'b10);
      last_e = e;
    end
  endtask

  initial begin
    int cnt;
    int gap;
    logic [9:0] c_w;
    logic [7:0] bv;
    rst_n = 1'b0; start = 1'b0; ctl = '0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out", {19'b0, busy, done, result, carryout, overout, zero, neg, cmpo, state_o},
          32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // directed cases
    issue(mk(0, 0, 0, 0, 0, 0, 0, 0), 8'h7F, 8'h01, 1'b0); wait_done("add_ovf", 40);
    issue(mk(0, 0, 0, 0, 1, 0, 1, 1), 8'h05, 8'h05, 1'b1); wait_done("sub_eq", 40);
    issue(mk(3, 0, 0, 0, 0, 0, 0, 0), 8'h81, 8'h03, 1'b0); wait_done("shl3", 40);
    issue(mk(2, 0, 0, 0, 0, 0, 0, 0), 8'hA5, 8'h09, 1'b0); wait_done("shr9", 40);
    issue(mk(2, 0, 0, 0, 0, 0, 0, 0), 8'hA5, 8'h00, 1'b0); wait_done("shr0", 40);
    issue(mk(4, 0, 0, 0, 0, 0, 0, 0), 8'h10, 8'h11, 1'b0); wait_done("mul", 40);
    issue(mk(7, 0, 0, 0, 0, 1, 0, 0), 8'h12, 8'h34, 1'b0); wait_done("add7_io", 40);

    // result holds while idle, done is a single pulse
    repeat (3) @(posedge clk);
    #1;
    check("hold_result", {19'b0, result, carryout, overout, zero, neg, cmpo, done},
          {19'b0, last_e, 1'b0});

    // start held high during a shl with different inputs; second op taken on done cycle
    begin
      logic [12:0] e2;
      int l2;
      issue(mk(3, 0, 0, 0, 0, 0, 0, 0), 8'h81, 8'h03, 1'b0);
      model(mk(0, 0, 0, 0, 0, 0, 0, 0), 8'h12, 8'h34, 1'b0, e2, l2);
      exp_q.push_back(e2);
      lat_q.push_back(l2);
      ctl = mk(0, 0, 0, 0, 0, 0, 0, 0); a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
      wait_done("held_first", 40);
      @(posedge clk); #1;
      start = 1'b0;
      wait_done("held_second", 40);
    end

    // randomized ops, some back-to-back on the done cycle
    for (int i = 0; i < 40; i++) begin
      c_w = 10'($urandom);
      bv = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 9)) : 8'($urandom);
      issue(c_w, 8'($urandom), bv, 1'($urandom));
      wait_done("rand", 40);
      gap = $urandom_range(0, 2);
      repeat (gap) @(posedge clk);
      if (gap > 0) #1;
    end

    // reset in the middle of a multi-cycle op
    issue(mk(4, 0, 0, 0, 0, 0, 0, 0), 8'hFF, 8'hFF, 1'b0);
    exp_q.delete();
    lat_q.delete();
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", {19'b0, busy, done, result, carryout, overout, zero, neg, cmpo, state_o},
          32'd0);
    @(negedge clk); rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) cnt++;
    end
    check("no_done_after_abort", 32'(cnt), 32'd0);
    issue(mk(0, 0, 0, 0, 0, 0, 1, 1), 8'h40, 8'h3F, 1'b1); wait_done("post_reset_add", 40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
